mips_bus_master: RTL

//  Initiator side of the CPU memory bus (address/read/write/waitrequest/writedata/byteenable/readdata).

---
 rtl/mips_bus_master.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_bus_master.sv
// -----------------------------------------------------------------------------
// mips_bus_master
// Initiator side of the CPU memory bus. This block takes one load or store
// request at a time from the core pipeline. It turns the request into a
// read/write bus transaction with a word address and byte enables, and it
// holds the transaction stable while the responder asserts waitrequest. Load
// data is lane-aligned and sign- or zero-extended before it is returned.
//
// Parameters
//   WAIT_TIMEOUT  consecutive waitrequest cycles before abort (0 = never)
//
// Ports
//   clk, reset    clock / asynchronous active-high reset
//   req_valid     core request present
//   req_ready     block idle, request will be accepted
//   req_write     1 = store, 0 = load
//   req_size      0 byte, 1 half, 2 word, 3 illegal
//   req_signed    sign-extend byte/half loads
//   req_addr      byte address
//   req_wdata     store data, LSB-justified
//   resp_valid    one-cycle completion pulse
//   resp_error    misaligned / illegal size / timeout (with resp_valid)
//   resp_rdata    aligned load result (with resp_valid)
//   address       bus word address ([1:0] always 0)
//   read, write   bus strobes
//   waitrequest   responder stall
//   writedata     lane-replicated store data
//   byteenable    lane enables
//   readdata      bus read data, valid the cycle after read is accepted
// -----------------------------------------------------------------------------
module mips_bus_master #(
    parameter int unsigned WAIT_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] resp_rdata,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    localparam int unsigned TW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLIM = (WAIT_TIMEOUT == 0) ? '0 : TW'(WAIT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        RDATA = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;

    logic [31:0]   r_address,    w_address_nxt;
    logic          r_read,       w_read_nxt;
    logic          r_write,      w_write_nxt;
    logic [31:0]   r_writedata,  w_writedata_nxt;
    logic [3:0]    r_byteenable, w_byteenable_nxt;
    logic          r_resp_valid, w_resp_valid_nxt;
    logic          r_resp_error, w_resp_error_nxt;
    logic [31:0]   r_resp_rdata, w_resp_rdata_nxt;
    logic [TW-1:0] r_timer,      w_timer_nxt;
    logic [1:0]    r_lane,       w_lane_nxt;
    logic [1:0]    r_size,       w_size_nxt;
    logic          r_signed,     w_signed_nxt;

    logic          w_accept;
    logic          w_legal;
    logic          w_timeout;
    logic [3:0]    w_be;
    logic [31:0]   w_wd;
    logic [31:0]   w_load_data;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;

    assign req_ready  = (r_state == IDLE);
    assign w_accept   = req_valid && req_ready;
    // The abort happens on the edge that would make the stall count reach WAIT_TIMEOUT.
    assign w_timeout  = (WAIT_TIMEOUT != 0) && waitrequest && (r_timer == TLIM);

    assign address    = r_address;
    assign read       = r_read;
    assign write      = r_write;
    assign writedata  = r_writedata;
    assign byteenable = r_byteenable;
    assign resp_valid = r_resp_valid;
    assign resp_error = r_resp_error;
    assign resp_rdata = r_resp_rdata;

    // Request decode: alignment, lane enables, store-data replication.
    always_comb begin
        w_legal = 1'b0;
        w_be    = 4'b0000;
        w_wd    = req_wdata;
        case (req_size)
            2'd0: begin
                w_legal = 1'b1;
                w_be    = 4'b0001 << req_addr[1:0];
                w_wd    = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                w_legal = ~req_addr[0];
                w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wd    = {2{req_wdata[15:0]}};
            end
            2'd2: begin
                w_legal = (req_addr[1:0] == 2'b00);
                w_be    = 4'b1111;
                w_wd    = req_wdata;
            end
            default: begin
                w_legal = 1'b0;
                w_be    = 4'b0000;
                w_wd    = req_wdata;
            end
        endcase
    end

    // Load alignment and extension, using the lane and size captured at accept.
    always_comb begin
        case (r_lane)
            2'd0:    w_byte = readdata[7:0];
            2'd1:    w_byte = readdata[15:8];
            2'd2:    w_byte = readdata[23:16];
            default: w_byte = readdata[31:24];
        endcase
        w_half = r_lane[1] ? readdata[31:16] : readdata[15:0];
        case (r_size)
            2'd0:    w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
            2'd1:    w_load_data = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load_data = readdata;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_address    <= '0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_writedata  <= '0;
            r_byteenable <= '0;
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_resp_rdata <= '0;
            r_timer      <= '0;
            r_lane       <= '0;
            r_size       <= '0;
            r_signed     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_address    <= w_address_nxt;
            r_read       <= w_read_nxt;
            r_write      <= w_write_nxt;
            r_writedata  <= w_writedata_nxt;
            r_byteenable <= w_byteenable_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_error <= w_resp_error_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_timer      <= w_timer_nxt;
            r_lane       <= w_lane_nxt;
            r_size       <= w_size_nxt;
            r_signed     <= w_signed_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && w_legal) begin
                    w_state_nxt = BUS;
                end
            end
            BUS: begin
                if (waitrequest) begin
                    if (w_timeout) begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_state_nxt = r_write ? IDLE : RDATA;
                end
            end
            RDATA: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Next values for the registered outputs and the captured request fields.
    always_comb begin
        w_address_nxt    = r_address;
        w_read_nxt       = r_read;
        w_write_nxt      = r_write;
        w_writedata_nxt  = r_writedata;
        w_byteenable_nxt = r_byteenable;
        w_resp_valid_nxt = 1'b0;
        w_resp_error_nxt = 1'b0;
        w_resp_rdata_nxt = r_resp_rdata;
        w_timer_nxt      = r_timer;
        w_lane_nxt       = r_lane;
        w_size_nxt       = r_size;
        w_signed_nxt     = r_signed;
        case (r_state)
            IDLE: begin
                w_timer_nxt = '0;
                if (w_accept) begin
                    if (w_legal) begin
                        w_address_nxt    = {req_addr[31:2], 2'b00};
                        w_byteenable_nxt = w_be;
                        w_writedata_nxt  = w_wd;
                        w_read_nxt       = ~req_write;
                        w_write_nxt      = req_write;
                        w_lane_nxt       = req_addr[1:0];
                        w_size_nxt       = req_size;
                        w_signed_nxt     = req_signed;
                    end else begin
                        w_resp_valid_nxt = 1'b1;
                        w_resp_error_nxt = 1'b1;
                        w_resp_rdata_nxt = '0;
                    end
                end
            end
            BUS: begin
                if (waitrequest) begin
                    if (w_timeout) begin
                        w_read_nxt       = 1'b0;
                        w_write_nxt      = 1'b0;
                        w_resp_valid_nxt = 1'b1;
                        w_resp_error_nxt = 1'b1;
                        w_resp_rdata_nxt = '0;
                        w_timer_nxt      = '0;
                    end else if (WAIT_TIMEOUT != 0) begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end else begin
                    w_read_nxt  = 1'b0;
                    w_write_nxt = 1'b0;
                    w_timer_nxt = '0;
                    if (r_write) begin
                        w_resp_valid_nxt = 1'b1;
                        w_resp_rdata_nxt = '0;
                    end
                end
            end
            RDATA: begin
                w_resp_valid_nxt = 1'b1;
                w_resp_rdata_nxt = w_load_data;
            end
            default: begin
                w_read_nxt  = 1'b0;
                w_write_nxt = 1'b0;
            end
        endcase
    end

endmodule
